ssd_scan_ctrl: RTL and testbench

Parametrised seven-segment scan controller for the Nexys board display path. It takes packed 5-bit glyph codes, decimal-point, blank and blink requests for N digits and time-multiplexes them onto active-low anodes and cathodes. It adds per-digit blink, PWM brightness, an anti-ghosting guard cycle and frame-synchronous (tear-free) input sampling. It sits between game/status logic and the board pins.

---
 rtl/ssd_scan_ctrl.sv | 164 ++++++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_ctrl.sv
// Seven-segment scan controller: multiplexes N glyph/dp/blank/blink digits onto
// active-low anodes and cathodes with PWM brightness, blink and a guard cycle.
module ssd_scan_ctrl #(
    parameter int N_DIGITS   = 8,
    parameter int SCAN_DIV_W = 17,
    parameter int BLINK_W    = 26,
    parameter int BRIGHT_W   = 3,
    localparam int IDX_W     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [5*N_DIGITS-1:0] digits,
    input  logic [N_DIGITS-1:0]   dp,
    input  logic [N_DIGITS-1:0]   blank,
    input  logic [N_DIGITS-1:0]   blink,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [N_DIGITS-1:0]   An,
    output logic [7:0]            Cath,
    output logic                  frame_start,
    output logic [IDX_W-1:0]      scan_idx
);

    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0]   AN_ONE   = {{(N_DIGITS-1){1'b0}}, 1'b1};
    localparam logic [N_DIGITS-1:0]   AN_OFF   = {N_DIGITS{1'b1}};
    localparam logic [SCAN_DIV_W-1:0] PRE_ZERO = {SCAN_DIV_W{1'b0}};

    // Glyph code to active-low abcdefg; unused codes stay dark.
    function automatic logic [6:0] seg_decode(input logic [4:0] code);
        logic [6:0] seg;
        case (code)
            5'd0:    seg = 7'b0000001;
            5'd1:    seg = 7'b1001111;
            5'd2:    seg = 7'b0010010;
            5'd3:    seg = 7'b0000110;
            5'd4:    seg = 7'b1001100;
            5'd5:    seg = 7'b0100100;
            5'd6:    seg = 7'b0100000;
            5'd7:    seg = 7'b0001111;
            5'd8:    seg = 7'b0000000;
            5'd9:    seg = 7'b0000100;
            5'd10:   seg = 7'b0001000;
            5'd11:   seg = 7'b1100000;
            5'd12:   seg = 7'b0110001;
            5'd13:   seg = 7'b1000010;
            5'd14:   seg = 7'b0110000;
            5'd15:   seg = 7'b0111000;
            5'd16:   seg = 7'b1111111;
            5'd17:   seg = 7'b1000100;
            5'd18:   seg = 7'b0000010;
            5'd19:   seg = 7'b1110001;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    logic [SCAN_DIV_W-1:0] pre_r;
    logic [IDX_W-1:0]      scan_idx_r;
    logic [BLINK_W-1:0]    bcnt_r;
    logic [5*N_DIGITS-1:0] sh_digits_r;
    logic [N_DIGITS-1:0]   sh_dp_r;
    logic [N_DIGITS-1:0]   sh_blank_r;
    logic [N_DIGITS-1:0]   sh_blink_r;
    logic [N_DIGITS-1:0]   an_r;
    logic [7:0]            cath_r;

    logic                  pre_wrap_s;
    logic                  last_digit_s;
    logic                  snap_s;
    logic [4:0]            glyph_s;
    logic                  dp_sel_s;
    logic                  blank_sel_s;
    logic                  blink_sel_s;
    logic                  bright_ok_s;
    logic                  on_s;
    logic [N_DIGITS-1:0]   an_next_s;
    logic [7:0]            cath_next_s;

    assign pre_wrap_s   = &pre_r;
    assign last_digit_s = (scan_idx_r == LAST_IDX);
    assign snap_s       = pre_wrap_s & last_digit_s;

    // Prescaler, digit index and blink counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pre_r      <= PRE_ZERO;
            scan_idx_r <= {IDX_W{1'b0}};
            bcnt_r     <= {BLINK_W{1'b0}};
        end else begin
            pre_r  <= pre_r + SCAN_DIV_W'(1);
            bcnt_r <= bcnt_r + BLINK_W'(1);
            if (pre_wrap_s) begin
                scan_idx_r <= last_digit_s ? {IDX_W{1'b0}} : scan_idx_r + IDX_W'(1);
            end else begin
                scan_idx_r <= scan_idx_r;
            end
        end
    end

    // Frame snapshot: loaded on the same edge that wraps back to digit 0.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sh_digits_r <= {N_DIGITS{5'b10000}};
            sh_dp_r     <= {N_DIGITS{1'b0}};
            sh_blank_r  <= {N_DIGITS{1'b1}};
            sh_blink_r  <= {N_DIGITS{1'b0}};
        end else if (snap_s) begin
            sh_digits_r <= digits;
            sh_dp_r     <= dp;
            sh_blank_r  <= blank;
            sh_blink_r  <= blink;
        end else begin
            sh_digits_r <= sh_digits_r;
            sh_dp_r     <= sh_dp_r;
            sh_blank_r  <= sh_blank_r;
            sh_blink_r  <= sh_blink_r;
        end
    end

    // Select the shadowed attributes of the digit being scanned.
    always_comb begin
        glyph_s     = 5'b10000;
        dp_sel_s    = 1'b0;
        blank_sel_s = 1'b1;
        blink_sel_s = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            glyph_s     = (scan_idx_r == IDX_W'(i)) ? sh_digits_r[5*i +: 5] : glyph_s;
            dp_sel_s    = (scan_idx_r == IDX_W'(i)) ? sh_dp_r[i]            : dp_sel_s;
            blank_sel_s = (scan_idx_r == IDX_W'(i)) ? sh_blank_r[i]         : blank_sel_s;
            blink_sel_s = (scan_idx_r == IDX_W'(i)) ? sh_blink_r[i]         : blink_sel_s;
        end
    end

    // pre == 0 is the guard cycle that keeps all anodes high between digits.
    always_comb begin
        bright_ok_s = (pre_r[SCAN_DIV_W-1 -: BRIGHT_W] <= brightness);
        on_s        = ~blank_sel_s & ~(blink_sel_s & bcnt_r[BLINK_W-1]) &
                      (pre_r != PRE_ZERO) & bright_ok_s;
        if (on_s) begin
            an_next_s   = ~(AN_ONE << scan_idx_r);
            cath_next_s = {seg_decode(glyph_s), ~dp_sel_s};
        end else begin
            an_next_s   = AN_OFF;
            cath_next_s = 8'hFF;
        end
    end

    // Registered pin drivers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            an_r   <= AN_OFF;
            cath_r <= 8'hFF;
        end else begin
            an_r   <= an_next_s;
            cath_r <= cath_next_s;
        end
    end

    assign An          = an_r;
    assign Cath        = cath_r;
    assign frame_start = snap_s;
    assign scan_idx    = scan_idx_r;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Scoreboard bench for ssd_scan_ctrl: a cycle model pushes expected pin values
// each clock, and each scenario task pops and compares them.
module tb_ssd_scan_ctrl;

    localparam int N   = 3;
    localparam int SW  = 4;
    localparam int BW  = 6;
    localparam int BRW = 2;

    logic           Clk = 1'b0;
    logic           Reset = 1'b1;
    logic [5*N-1:0] digits = 15'd0;
    logic [N-1:0]   dp = 3'b000;
    logic [N-1:0]   blank = 3'b111;
    logic [N-1:0]   blink = 3'b000;
    logic [BRW-1:0] brightness = 2'd3;
    logic [N-1:0]   An;
    logic [7:0]     Cath;
    logic           frame_start;
    logic [1:0]     scan_idx;

    always #5 Clk = ~Clk;

    ssd_scan_ctrl #(.N_DIGITS(N), .SCAN_DIV_W(SW), .BLINK_W(BW), .BRIGHT_W(BRW)) dut (
        .Clk(Clk), .Reset(Reset), .digits(digits), .dp(dp), .blank(blank),
        .blink(blink), .brightness(brightness), .An(An), .Cath(Cath),
        .frame_start(frame_start), .scan_idx(scan_idx)
    );

    typedef struct packed {
        logic [2:0] an;
        logic [7:0] cath;
    } pins_t;

    localparam logic [6:0] SEG_TBL [32] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
        7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000, 7'b1111111, 7'b1000100,
        7'b0000010, 7'b1110001, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111,
        7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111,
        7'b1111111, 7'b1111111};

    pins_t    q[$];
    int       checks = 0;
    int       errors = 0;
    int       m_pre = 0, m_idx = 0, m_bcnt = 0;
    logic [4:0] sh_dig [N];
    logic [N-1:0] sh_dp, sh_blank, sh_blink;
    pins_t    e;

    function automatic pins_t model_pins();
        pins_t p;
        p.an   = 3'b111;
        p.cath = 8'hFF;
        if (!sh_blank[m_idx] && !(sh_blink[m_idx] && m_bcnt >= 32) && m_pre != 0 &&
            m_pre < 4 * (int'(brightness) + 1)) begin
            p.an   = 3'b111 ^ (3'b001 << m_idx);
            p.cath = {SEG_TBL[sh_dig[m_idx]], ~sh_dp[m_idx]};
        end
        return p;
    endfunction

    function automatic logic model_fs();
        return (m_pre == 15 && m_idx == 2);
    endfunction

    task automatic tick();
        pins_t x;
        logic  snap;
        if (Reset) begin
            x.an   = 3'b111;
            x.cath = 8'hFF;
        end else begin
            x = model_pins();
        end
        q.push_back(x);
        @(posedge Clk);
        if (Reset) begin
            m_pre = 0; m_idx = 0; m_bcnt = 0;
            for (int i = 0; i < N; i++) sh_dig[i] = 5'b10000;
            sh_dp = 3'b000; sh_blank = 3'b111; sh_blink = 3'b000;
        end else begin
            snap = model_fs();
            if (snap) begin
                for (int i = 0; i < N; i++) sh_dig[i] = digits[5*i +: 5];
                sh_dp = dp; sh_blank = blank; sh_blink = blink;
            end
            if (m_pre == 15) m_idx = (m_idx == 2) ? 0 : m_idx + 1;
            m_pre  = (m_pre + 1) % 16;
            m_bcnt = (m_bcnt + 1) % 64;
        end
        #1;
    endtask

    task automatic test_reset();
        int fs_at = -1;
        int lit = 0;
        Reset = 1'b1;
        digits = {5'd2, 5'd1, 5'd0}; dp = 3'b001; blank = 3'b000; blink = 3'b000;
        brightness = 2'd3;
        for (int c = 0; c < 3; c++) begin
            tick();
            e = q.pop_front();
            checks++; if (An !== e.an || Cath !== e.cath) begin errors++;
                $display("FAIL reset_pins An=%b Cath=%b want %b %b", An, Cath, e.an, e.cath); end
            checks++; if (frame_start !== model_fs() || scan_idx !== 2'(m_idx)) begin errors++;
                $display("FAIL reset_state fs=%b idx=%0d want %b %0d", frame_start, scan_idx, model_fs(), m_idx); end
        end
        Reset = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            tick();
            e = q.pop_front();
            checks++; if (An !== e.an || Cath !== e.cath) begin errors++;
                $display("FAIL first_frame_pins An=%b Cath=%b want %b %b", An, Cath, e.an, e.cath); end
            checks++; if (frame_start !== model_fs() || scan_idx !== 2'(m_idx)) begin errors++;
                $display("FAIL first_frame_state fs=%b idx=%0d want %b %0d", frame_start, scan_idx, model_fs(), m_idx); end
            if (frame_start === 1'b1 && fs_at < 0) fs_at = c;
            if (c <= 48 && An !== 3'b111) lit++;
        end
        checks++; if (fs_at != 47) begin errors++; $display("FAIL first_frame_start at=%0d want 47", fs_at); end
        checks++; if (lit != 0) begin errors++; $display("FAIL dark_before_snapshot lit=%0d want 0", lit); end
    endtask

    task automatic test_scan();
        int n0 = 0, n1 = 0, n2 = 0, nd = 0;
        for (int c = 0; c < 96 + 48; c++) begin
            tick();
            e = q.pop_front();
            checks++; if (An !== e.an || Cath !== e.cath) begin errors++;
                $display("FAIL scan_pins An=%b Cath=%b want %b %b", An, Cath, e.an, e.cath); end
            checks++; if (frame_start !== model_fs() || scan_idx !== 2'(m_idx)) begin errors++;
                $display("FAIL scan_state fs=%b idx=%0d want %b %0d", frame_start, scan_idx, model_fs(), m_idx); end
            if (c >= 96) begin
                if (An === 3'b110 && Cath === 8'b00000010) n0++;
                if (An === 3'b101 && Cath === 8'b10011111) n1++;
                if (An === 3'b011 && Cath === 8'b00100101) n2++;
                if (An === 3'b111 && Cath === 8'hFF) nd++;
            end
        end
        checks++; if (n0 != 15 || n1 != 15 || n2 != 15 || nd != 3) begin errors++;
            $display("FAIL scan_counts d0=%0d d1=%0d d2=%0d dark=%0d want 15 15 15 3", n0, n1, n2, nd); end
    endtask

    task automatic test_brightness();
        logic [1:0] lv [3] = '{2'd1, 2'd0, 2'd3};
        int         want [3] = '{21, 9, 45};
        for (int k = 0; k < 3; k++) begin
            int lit = 0;
            brightness = lv[k];
            for (int c = 0; c < 49; c++) begin
                tick();
                e = q.pop_front();
                checks++; if (An !== e.an || Cath !== e.cath) begin errors++;
                    $display("FAIL bright_pins An=%b Cath=%b want %b %b", An, Cath, e.an, e.cath); end
                checks++; if (frame_start !== model_fs() || scan_idx !== 2'(m_idx)) begin errors++;
                    $display("FAIL bright_state fs=%b idx=%0d want %b %0d", frame_start, scan_idx, model_fs(), m_idx); end
                if (c >= 1 && An !== 3'b111) lit++;
            end
            checks++; if (lit != want[k]) begin errors++;
                $display("FAIL bright_duty level=%0d lit=%0d want %0d", lv[k], lit, want[k]); end
        end
    endtask

    task automatic test_blink_glyph();
        int d1_on = 0, d1_bad = 0, d0_on = 0, d0_bad = 0;
        logic ph;
        blink = 3'b010; digits = {5'd2, 5'd1, 5'b11111}; dp = 3'b000; brightness = 2'd3;
        for (int c = 0; c < 96 + 192; c++) begin
            ph = (m_bcnt >= 32);
            tick();
            e = q.pop_front();
            checks++; if (An !== e.an || Cath !== e.cath) begin errors++;
                $display("FAIL blink_pins An=%b Cath=%b want %b %b", An, Cath, e.an, e.cath); end
            checks++; if (frame_start !== model_fs() || scan_idx !== 2'(m_idx)) begin errors++;
                $display("FAIL blink_state fs=%b idx=%0d want %b %0d", frame_start, scan_idx, model_fs(), m_idx); end
            if (c >= 96) begin
                if (An === 3'b101 && ph) d1_bad++;
                if (An === 3'b101 && !ph) d1_on++;
                if (An === 3'b110) d0_on++;
                if (An === 3'b110 && Cath !== 8'hFF) d0_bad++;
            end
        end
        checks++; if (d1_bad != 0 || d1_on == 0) begin errors++;
            $display("FAIL blink_phase lit_in_dark=%0d lit_in_bright=%0d want 0 and >0", d1_bad, d1_on); end
        checks++; if (d0_on != 60 || d0_bad != 0) begin errors++;
            $display("FAIL glyph_blank_code on=%0d non_ff=%0d want 60 0", d0_on, d0_bad); end
    endtask

    task automatic test_tear_free();
        int  seen3 = 0, after3 = 0;
        logic found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            tick();
            e = q.pop_front();
            checks++; if (An !== e.an || Cath !== e.cath) begin errors++;
                $display("FAIL tear_pins An=%b Cath=%b want %b %b", An, Cath, e.an, e.cath); end
            checks++; if (frame_start !== model_fs() || scan_idx !== 2'(m_idx)) begin errors++;
                $display("FAIL tear_state fs=%b idx=%0d want %b %0d", frame_start, scan_idx, model_fs(), m_idx); end
            if (m_idx == 1) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL tear_wait_idx1 timeout"); end
        digits = {5'd3, 5'd3, 5'd3}; blink = 3'b000;
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            tick();
            e = q.pop_front();
            checks++; if (An !== e.an || Cath !== e.cath) begin errors++;
                $display("FAIL tear_hold_pins An=%b Cath=%b want %b %b", An, Cath, e.an, e.cath); end
            checks++; if (frame_start !== model_fs() || scan_idx !== 2'(m_idx)) begin errors++;
                $display("FAIL tear_hold_state fs=%b idx=%0d want %b %0d", frame_start, scan_idx, model_fs(), m_idx); end
            if (Cath[7:1] === 7'b0000110) seen3++;
            if (frame_start === 1'b1) found = 1'b1;
        end
        checks++; if (!found || seen3 != 0) begin errors++;
            $display("FAIL tear_free found=%b early_new_glyph=%0d want 1 0", found, seen3); end
        for (int c = 0; c < 49; c++) begin
            tick();
            e = q.pop_front();
            checks++; if (An !== e.an || Cath !== e.cath) begin errors++;
                $display("FAIL tear_new_pins An=%b Cath=%b want %b %b", An, Cath, e.an, e.cath); end
            checks++; if (frame_start !== model_fs() || scan_idx !== 2'(m_idx)) begin errors++;
                $display("FAIL tear_new_state fs=%b idx=%0d want %b %0d", frame_start, scan_idx, model_fs(), m_idx); end
            if (Cath === 8'b00001101) after3++;
        end
        checks++; if (after3 != 45) begin errors++; $display("FAIL tear_new_frame lit=%0d want 45", after3); end
    endtask

    task automatic test_reset_mid_scan();
        logic found = 1'b0;
        int   fs_at = -1;
        for (int c = 0; c < 100 && !found; c++) begin
            tick();
            e = q.pop_front();
            checks++; if (An !== e.an || Cath !== e.cath) begin errors++;
                $display("FAIL mid_pins An=%b Cath=%b want %b %b", An, Cath, e.an, e.cath); end
            checks++; if (frame_start !== model_fs() || scan_idx !== 2'(m_idx)) begin errors++;
                $display("FAIL mid_state fs=%b idx=%0d want %b %0d", frame_start, scan_idx, model_fs(), m_idx); end
            if (m_idx == 1 && m_pre == 5) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL mid_wait timeout"); end
        Reset = 1'b1;
        tick();
        e = q.pop_front();
        checks++; if (An !== 3'b111 || Cath !== 8'hFF || An !== e.an || Cath !== e.cath) begin errors++;
            $display("FAIL mid_reset_pins An=%b Cath=%b want 111 ff", An, Cath); end
        checks++; if (scan_idx !== 2'd0 || dut.pre_r !== 4'd0 || frame_start !== 1'b0) begin errors++;
            $display("FAIL mid_reset_state idx=%0d pre=%0d fs=%b want 0 0 0", scan_idx, dut.pre_r, frame_start); end
        Reset = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            tick();
            e = q.pop_front();
            checks++; if (An !== e.an || Cath !== e.cath) begin errors++;
                $display("FAIL post_reset_pins An=%b Cath=%b want %b %b", An, Cath, e.an, e.cath); end
            checks++; if (frame_start !== model_fs() || scan_idx !== 2'(m_idx)) begin errors++;
                $display("FAIL post_reset_state fs=%b idx=%0d want %b %0d", frame_start, scan_idx, model_fs(), m_idx); end
            if (frame_start === 1'b1 && fs_at < 0) fs_at = c;
        end
        checks++; if (fs_at != 47) begin errors++; $display("FAIL post_reset_frame_start at=%0d want 47", fs_at); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_brightness();
        test_blink_glyph();
        test_tear_free();
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
